mvm_stream: RTL and testbench
=============================

# mvm_stream

Parametrised streaming signed matrix-vector multiplier, y = A·x, for A of M×N and x of length N. Next generation of the team's fixed 3×3 MVM engine. Adds:
- configurable dimensions and widths;
- optional saturating arithmetic;
- matrix reuse across transactions (`keep_a`), which skips the reload of A.

It sits between an upstream valid/ready byte stream and a downstream valid/ready result stream.

## Interface
- `M`, 3, number of rows of A and outputs per transaction (≥1)
- `N`, 3, number of columns of A and length of x (≥1)
- `IW`, 8, signed input element width
- `OW`, 16, signed accumulator/output width (≥ 2·IW)
- `SAT`, 0, 0 = wrap on overflow, 1 = saturate on overflow
- `clk` in 1: single clock, all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `s_valid` in 1: input beat valid
- `s_ready` out 1: block can accept an input beat
- `data_in` in IW: signed A or x element
- `keep_a` in 1: sampled on the first beat of a transaction; 1 = reuse the stored A
- `m_valid` out 1: output beat valid
- `m_ready` in 1: downstream accepts output beat
- `data_out` out OW: signed y element
- `overflow` out 1: overflow flag for the current `data_out`

## Operation
- Handshake: a beat transfers on a rising edge with valid & ready both high. `data_in` is ignored otherwise and may be X.
- States:
  - IDLE: `s_ready` = 1. On the first accepted beat, go to LOAD_X if `keep_a` = 1 and `a_loaded` = 1, storing the beat as x[0]. Otherwise go to LOAD_A, storing the beat as A[0][0].
  - LOAD_A: `s_ready` = 1. Accept M·N elements, row-major, counting the IDLE beat. After the last one go to LOAD_X and set `a_loaded`.
  - LOAD_X: `s_ready` = 1. Accept N elements, counting an IDLE beat if one landed in x. After the last one go to MAC.
  - MAC: `s_ready` = 0. For each row i, y[i] = Σ_j A[i][j]·x[j], with j ascending. One product is issued per cycle. Results and flags are written to an M-entry output buffer.
  - DRAIN: `m_valid` = 1. Presents y[0]..y[M-1] in order; the index advances on each handshake. After y[M-1] is accepted, go to IDLE.
- Arithmetic:
  - Each product is exact in 2·IW bits and is sign-extended to OW.
  - An add overflows when both operands have the same sign and the sum's sign differs.
  - SAT = 0: the sum wraps modulo 2^OW.
  - SAT = 1: the sum clamps to 2^(OW-1)-1 or -2^(OW-1), and later adds in that row start from the clamped value.
  - `overflow[i]` is sticky: it is set if any add in row i overflowed, and clears at the start of each row.
- `a_loaded` is cleared only by reset. The A and x storage is not cleared by reset.
- `keep_a` is ignored on every beat except the first of a transaction.

## Timing
- Reset values: `s_ready` = 0 while `reset_n` = 0 and 1 from the first edge after deassertion. `m_valid` = 0, `data_out` = 0, `overflow` = 0, state = IDLE, `a_loaded` = 0, all counters = 0.
- Reset asserted mid-transaction (any state) aborts immediately. Partial data is discarded and no output beat is produced.
- `m_valid` rises exactly M·N+4 cycles after the edge that accepted the last x element. This is fixed and independent of data or `keep_a`.
- `data_out` and `overflow` come straight from registers. They are stable while `m_valid` = 1 and `m_ready` = 0.
- Back-to-back output: if `m_ready` is held at 1, one output is produced per cycle. `m_valid` drops on the edge that accepts y[M-1].
- `s_ready` is 0 throughout MAC and DRAIN; there is no overlap of load and drain.
- The earliest next input beat is the cycle after the final output handshake.
- Minimum transaction length: (M·N or 0)+N input cycles, plus M·N+4, plus M output cycles.

## Structure
- `mvm_pkg` holds:
  - the state enum (IDLE, LOAD_A, LOAD_X, MAC, DRAIN);
  - `function automatic` helpers for overflow detection and saturation on OW;
  - a `clog2`-based address-width localparam helper.
- Sub-module `mvm_mac` (parameters IW, OW, SAT) holds:
  - the operand register, product register and accumulator;
  - the sticky overflow flag;
  - a `clear` input that starts a row and a `valid_in`/`valid_out` pipeline.
- A and x storage, the output buffer, and the FSM with its counters live in `mvm_stream`. Storage is synchronous-read register arrays.

## Test plan
- M=N=3, SAT=0, A = 1,-8,3,9,-5,11,-7,8,-9, x = 1,-22,3, random valid/ready → y = 186, 152, -210, all with overflow = 0.
- Same configuration, A = 10,11,12,127,127,127,1,2,3, x = 127,127,127 → y = 4191, -17149 (overflow = 1), 762. With SAT = 1 → y = 4191, 32767 (overflow = 1), 762.
- SAT=1, A row = -128,-128,-128, x = 127,127,127 → -32768 with overflow = 1. With SAT = 0 → 16768 with overflow = 1.
- `keep_a` = 1 after the first test, x = 1,1,1 (only 3 input beats accepted) → y = -4, 15, -8. `keep_a` = 1 straight after reset → the full 12-beat load occurs.
- `m_ready` held at 0 for 20 cycles during DRAIN → `data_out` and `overflow` unchanged. Then `m_ready` = 1 continuously → 3 outputs on 3 consecutive edges.
- `reset_n` pulsed low during MAC → outputs at reset values, no `m_valid`. A following full transaction is correct.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared state encoding and arithmetic helpers for the streaming matrix-vector multiplier.
package mvm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_X,
        MAC,
        DRAIN
    } state_e;

    // Index width for an n-entry array; a single entry still needs one bit.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
        return (a_sign == b_sign) && (s_sign != a_sign);
    endfunction

    // Clamp value on a w-bit signed range, returned wide; callers truncate to w bits.
    function automatic logic [63:0] sat_val(input int w, input logic neg);
        logic [63:0] max_pos;
        max_pos = (64'd1 << (w - 1)) - 64'd1;
        return neg ? ~max_pos : max_pos;
    endfunction

endpackage

// File: rtl/mvm_mac.sv
// Three-stage multiply-accumulate: operand register, product register, accumulator.
// valid_out pulses for one cycle once the last product of a row has been added.
module mvm_mac
    import mvm_pkg::*;
#(
    parameter int IW  = 8,
    parameter int OW  = 16,
    parameter int SAT = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid_in,
    input  logic                 clear,
    input  logic                 last,
    input  logic signed [IW-1:0] a_in,
    input  logic signed [IW-1:0] x_in,
    output logic                 valid_out,
    output logic signed [OW-1:0] acc,
    output logic                 overflow
);
    localparam int PW = 2 * IW;

    logic [1:0]           vld_pipe_q, vld_pipe_d;
    logic [1:0]           clr_pipe_q, clr_pipe_d;
    logic [1:0]           last_pipe_q, last_pipe_d;
    logic signed [IW-1:0] op_a_q, op_a_d, op_x_q, op_x_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic signed [OW-1:0] acc_q, acc_d;
    logic signed [OW-1:0] base, prod_ext, sum;
    logic                 ovf_q, ovf_d, done_q, done_d, add_of;

    always_comb begin
        vld_pipe_d  = {vld_pipe_q[0], valid_in};
        clr_pipe_d  = {clr_pipe_q[0], clear};
        last_pipe_d = {last_pipe_q[0], last};
        op_a_d      = valid_in ? a_in : op_a_q;
        op_x_d      = valid_in ? x_in : op_x_q;
        prod_d      = vld_pipe_q[0] ? PW'(op_a_q) * PW'(op_x_q) : prod_q;

        // A row starts from zero, so its first add can never overflow.
        base     = clr_pipe_q[1] ? '0 : acc_q;
        prod_ext = OW'(prod_q);
        sum      = base + prod_ext;
        add_of   = add_ovf(base[OW-1], prod_ext[OW-1], sum[OW-1]);
        if (SAT != 0 && add_of) sum = OW'(sat_val(OW, base[OW-1]));

        acc_d = acc_q;
        ovf_d = ovf_q;
        if (vld_pipe_q[1]) begin
            acc_d = sum;
            ovf_d = (clr_pipe_q[1] ? 1'b0 : ovf_q) | add_of;
        end
        done_d = vld_pipe_q[1] & last_pipe_q[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q  <= '0;
            clr_pipe_q  <= '0;
            last_pipe_q <= '0;
            op_a_q      <= '0;
            op_x_q      <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            clr_pipe_q  <= clr_pipe_d;
            last_pipe_q <= last_pipe_d;
            op_a_q      <= op_a_d;
            op_x_q      <= op_x_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    assign valid_out = done_q;
    assign acc       = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/mvm_stream.sv
// Streaming y = A*x: loads A (unless reused) and x from one byte stream, runs the MAC
// over every element, then drains the M results from a shifting output buffer.
module mvm_stream
    import mvm_pkg::*;
#(
    parameter int M   = 3,
    parameter int N   = 3,
    parameter int IW  = 8,
    parameter int OW  = 16,
    parameter int SAT = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [IW-1:0] data_in,
    input  logic                 keep_a,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [OW-1:0] data_out,
    output logic                 overflow
);
    localparam int MN  = M * N;
    localparam int AWA = addr_w(MN);
    localparam int AWX = addr_w(N);
    localparam int AWM = addr_w(M);
    localparam logic [AWA-1:0] LAST_A = AWA'(MN - 1);
    localparam logic [AWX-1:0] LAST_X = AWX'(N - 1);
    localparam logic [AWM-1:0] LAST_M = AWM'(M - 1);

    state_e                state_q, state_d;
    logic [AWA-1:0]        a_cnt_q, a_cnt_d;
    logic [AWX-1:0]        x_cnt_q, x_cnt_d;
    logic [AWM-1:0]        wr_q, wr_d;
    logic                  iss_done_q, iss_done_d;
    logic                  a_loaded_q, a_loaded_d;
    logic                  alive_q;
    logic [M-1:0][OW-1:0]  obuf_q, obuf_d;
    logic [M-1:0]          ovfb_q, ovfb_d;
    logic [MN-1:0][IW-1:0] a_mem_q;
    logic [N-1:0][IW-1:0]  x_mem_q;
    logic                  rd_vld_q, rd_vld_d, rd_clr_q, rd_clr_d, rd_last_q, rd_last_d;
    logic signed [IW-1:0]  rd_a_q, rd_a_d, rd_x_q, rd_x_d;
    logic                  a_we, x_we, issue, beat;
    logic                  mac_done, mac_ovf;
    logic signed [OW-1:0]  mac_acc;

    // s_ready stays low through reset and only rises on the first edge after release.
    assign s_ready  = alive_q && (state_q == IDLE || state_q == LOAD_A || state_q == LOAD_X);
    assign beat     = s_valid && s_ready;
    assign m_valid  = (state_q == DRAIN);
    assign data_out = obuf_q[0];
    assign overflow = ovfb_q[0];

    always_comb begin
        state_d    = state_q;
        a_cnt_d    = a_cnt_q;
        x_cnt_d    = x_cnt_q;
        wr_d       = wr_q;
        iss_done_d = iss_done_q;
        a_loaded_d = a_loaded_q;
        obuf_d     = obuf_q;
        ovfb_d     = ovfb_q;
        a_we       = 1'b0;
        x_we       = 1'b0;
        issue      = 1'b0;
        unique case (state_q)
            IDLE: if (beat) begin
                if (keep_a && a_loaded_q) begin
                    x_we = 1'b1;
                    if (LAST_X == '0) begin
                        iss_done_d = 1'b0;
                        state_d    = MAC;
                    end else begin
                        x_cnt_d = AWX'(1);
                        state_d = LOAD_X;
                    end
                end else begin
                    a_we = 1'b1;
                    if (LAST_A == '0) begin
                        a_loaded_d = 1'b1;
                        state_d    = LOAD_X;
                    end else begin
                        a_cnt_d = AWA'(1);
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_A: if (beat) begin
                a_we = 1'b1;
                if (a_cnt_q == LAST_A) begin
                    a_cnt_d    = '0;
                    a_loaded_d = 1'b1;
                    state_d    = LOAD_X;
                end else a_cnt_d = a_cnt_q + 1'b1;
            end
            LOAD_X: if (beat) begin
                x_we = 1'b1;
                if (x_cnt_q == LAST_X) begin
                    x_cnt_d    = '0;
                    iss_done_d = 1'b0;
                    state_d    = MAC;
                end else x_cnt_d = x_cnt_q + 1'b1;
            end
            MAC: begin
                // a_cnt walks A row-major while x_cnt tracks the column.
                if (!iss_done_q) begin
                    issue   = 1'b1;
                    x_cnt_d = (x_cnt_q == LAST_X) ? '0 : x_cnt_q + 1'b1;
                    if (a_cnt_q == LAST_A) begin
                        a_cnt_d    = '0;
                        iss_done_d = 1'b1;
                    end else a_cnt_d = a_cnt_q + 1'b1;
                end
                if (mac_done) begin
                    obuf_d[wr_q] = mac_acc;
                    ovfb_d[wr_q] = mac_ovf;
                    if (wr_q == LAST_M) begin
                        wr_d    = '0;
                        state_d = DRAIN;
                    end else wr_d = wr_q + 1'b1;
                end
            end
            DRAIN: if (m_ready) begin
                for (int i = 0; i < M - 1; i++) begin
                    obuf_d[i] = obuf_q[i+1];
                    ovfb_d[i] = ovfb_q[i+1];
                end
                obuf_d[M-1] = '0;
                ovfb_d[M-1] = 1'b0;
                if (wr_q == LAST_M) begin
                    wr_d    = '0;
                    state_d = IDLE;
                end else wr_d = wr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        rd_vld_d  = issue;
        rd_a_d    = issue ? a_mem_q[a_cnt_q] : rd_a_q;
        rd_x_d    = issue ? x_mem_q[x_cnt_q] : rd_x_q;
        rd_clr_d  = issue ? (x_cnt_q == '0) : rd_clr_q;
        rd_last_d = issue ? (x_cnt_q == LAST_X) : rd_last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            a_cnt_q    <= '0;
            x_cnt_q    <= '0;
            wr_q       <= '0;
            iss_done_q <= 1'b0;
            a_loaded_q <= 1'b0;
            alive_q    <= 1'b0;
            obuf_q     <= '0;
            ovfb_q     <= '0;
            rd_vld_q   <= 1'b0;
            rd_a_q     <= '0;
            rd_x_q     <= '0;
            rd_clr_q   <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_cnt_q    <= a_cnt_d;
            x_cnt_q    <= x_cnt_d;
            wr_q       <= wr_d;
            iss_done_q <= iss_done_d;
            a_loaded_q <= a_loaded_d;
            alive_q    <= 1'b1;
            obuf_q     <= obuf_d;
            ovfb_q     <= ovfb_d;
            rd_vld_q   <= rd_vld_d;
            rd_a_q     <= rd_a_d;
            rd_x_q     <= rd_x_d;
            rd_clr_q   <= rd_clr_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Operand storage survives reset; a_loaded_q alone decides whether A is usable.
    always_ff @(posedge clk) begin
        if (a_we) a_mem_q[a_cnt_q] <= data_in;
        if (x_we) x_mem_q[x_cnt_q] <= data_in;
    end

    mvm_mac #(.IW(IW), .OW(OW), .SAT(SAT)) u_mac (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid_in (rd_vld_q),
        .clear    (rd_clr_q),
        .last     (rd_last_q),
        .a_in     (rd_a_q),
        .x_in     (rd_x_q),
        .valid_out(mac_done),
        .acc      (mac_acc),
        .overflow (mac_ovf)
    );

endmodule

// File: tb/tb_mvm_stream.sv
// Drives a wrapping and a saturating mvm_stream with the same stream and checks both
// against an integer reference of y = A*x.
module tb_mvm_stream;
    localparam int M = 3, N = 3, IW = 8, OW = 16, MN = M * N;
    localparam longint MAXV = (longint'(1) << (OW - 1)) - 1;
    localparam longint MINV = -MAXV - 1;

    logic                 clk = 1'b0;
    logic                 reset_n, s_valid, keep_a, m_ready;
    logic signed [IW-1:0] data_in;
    logic                 s_ready_w, s_ready_s, m_valid_w, m_valid_s, ovf_w, ovf_s;
    logic signed [OW-1:0] dout_w, dout_s;

    int     n_err, n_chk;
    int     a_m[MN], a_new[MN], x_new[N];
    longint ew[M], es[M];
    bit     fw[M], fs[M];
    bit     a_loaded_m;

    always #5 clk = ~clk;

    mvm_stream #(.M(M), .N(N), .IW(IW), .OW(OW), .SAT(0)) dut_w (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready_w),
        .data_in(data_in), .keep_a(keep_a), .m_valid(m_valid_w), .m_ready(m_ready),
        .data_out(dout_w), .overflow(ovf_w));

    mvm_stream #(.M(M), .N(N), .IW(IW), .OW(OW), .SAT(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready_s),
        .data_in(data_in), .keep_a(keep_a), .m_valid(m_valid_s), .m_ready(m_ready),
        .data_out(dout_s), .overflow(ovf_s));

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap(input longint s);
        longint w;
        w = s & ((longint'(1) << OW) - 1);
        if (w > MAXV) w -= (longint'(1) << OW);
        return w;
    endfunction

    // Plain integer dot products; overflow means any partial sum left the OW range.
    task automatic model_y();
        longint aw, as, p, s;
        for (int i = 0; i < M; i++) begin
            aw = 0; as = 0; fw[i] = 0; fs[i] = 0;
            for (int j = 0; j < N; j++) begin
                p = longint'(a_m[i*N+j]) * longint'(x_new[j]);
                s = aw + p;
                if (s > MAXV || s < MINV) fw[i] = 1;
                aw = wrap(s);
                s = as + p;
                if (s > MAXV) begin fs[i] = 1; as = MAXV; end
                else if (s < MINV) begin fs[i] = 1; as = MINV; end
                else as = s;
            end
            ew[i] = aw;
            es[i] = as;
        end
    endtask

    task automatic send_beat(input int d, input bit k);
        int g, guard;
        g = $urandom_range(0, 2);
        repeat (g) begin
            @(negedge clk);
            s_valid = 1'b0;
            keep_a  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        s_valid = 1'b1;
        data_in = IW'(d);
        keep_a  = k;
        guard   = 0;
        while (!s_ready_w && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("s_ready_timeout", s_ready_w, 1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        keep_a = 1'($urandom_range(0, 1));
    endtask

    task automatic load(input bit keep);
        bit full, first;
        full  = !(keep && a_loaded_m);
        first = 1'b1;
        if (full) begin
            a_m = a_new;
            a_loaded_m = 1'b1;
            for (int i = 0; i < MN; i++) begin
                send_beat(a_new[i], first ? keep : 1'($urandom_range(0, 1)));
                first = 1'b0;
            end
        end
        for (int j = 0; j < N; j++) begin
            send_beat(x_new[j], first ? keep : 1'($urandom_range(0, 1)));
            first = 1'b0;
        end
    endtask

    task automatic check_out(input int i);
        chk("m_valid_w", m_valid_w, 1);
        chk("m_valid_s", m_valid_s, 1);
        chk("y_wrap", dout_w, ew[i]);
        chk("ovf_wrap", ovf_w, fw[i]);
        chk("y_sat", dout_s, es[i]);
        chk("ovf_sat", ovf_s, fs[i]);
    endtask

    // mode 0: random m_ready; mode 1: m_ready held low 20 cycles, then held high.
    task automatic drain(input int mode);
        int i, guard;
        i = 0; guard = 0;
        if (mode == 1) begin
            m_ready = 1'b0;
            repeat (20) begin
                check_out(0);
                @(negedge clk);
            end
        end
        while (i < M && guard < 200) begin
            m_ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            check_out(i);
            @(posedge clk);
            if (m_ready) i++;
            guard++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk("drain_count", i, M);
        chk("m_valid_end", m_valid_w, 0);
        chk("s_ready_end_w", s_ready_w, 1);
        chk("s_ready_end_s", s_ready_s, 1);
    endtask

    task automatic txn(input bit keep, input int mode);
        int n;
        load(keep);
        model_y();
        @(negedge clk);
        chk("s_ready_mac_w", s_ready_w, 0);
        chk("s_ready_mac_s", s_ready_s, 0);
        n = 0;
        while (!m_valid_w && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", n, MN + 4);
        drain(mode);
    endtask

    task automatic reset_mac();
        bit mv;
        load(1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_s_ready", s_ready_w, 0);
        chk("rst_m_valid", m_valid_w, 0);
        chk("rst_dout_w", dout_w, 0);
        chk("rst_ovf_w", ovf_w, 0);
        chk("rst_dout_s", dout_s, 0);
        @(negedge clk);
        reset_n = 1'b1;
        a_loaded_m = 1'b0;
        mv = 1'b0;
        repeat (20) begin
            @(negedge clk);
            mv |= m_valid_w | m_valid_s;
        end
        chk("rst_no_m_valid", mv, 0);
    endtask

    initial begin
        n_err = 0; n_chk = 0; a_loaded_m = 1'b0;
        reset_n = 1'b0; s_valid = 1'b0; data_in = '0; keep_a = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("init_s_ready", s_ready_w, 0);
        chk("init_m_valid", m_valid_w, 0);
        chk("init_dout", dout_w, 0);
        chk("init_ovf", ovf_w, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready_w, 1);

        // keep_a straight after reset must still load A
        a_new = '{10, 11, 12, 127, 127, 127, 1, 2, 3};
        x_new = '{127, 127, 127};
        txn(1'b1, 0);

        a_new = '{-128, -128, -128, 5, -7, 9, 0, 0, 0};
        x_new = '{127, 127, 127};
        txn(1'b0, 0);

        a_new = '{1, -8, 3, 9, -5, 11, -7, 8, -9};
        x_new = '{1, -22, 3};
        txn(1'b0, 0);

        x_new = '{1, 1, 1};
        txn(1'b1, 1);

        reset_mac();
        a_new = '{1, -8, 3, 9, -5, 11, -7, 8, -9};
        x_new = '{1, -22, 3};
        txn(1'b1, 0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < MN; i++) a_new[i] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < N; j++) x_new[j] = int'($urandom_range(0, 255)) - 128;
            txn(1'($urandom_range(0, 1)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
